sel_sequencer: RTL and testbench

SEL_SEQUENCER -- requirements
Module: sel_sequencer

---
 rtl/sel_sequencer.sv | 168 ++++++++++++++++
 tb/tb_sel_sequencer.sv | 134 +++++++++++++
 2 files changed

// File: rtl/sel_sequencer.sv
// sel_sequencer: debounced two-button controller producing a registered
// 2:1 mux select. MANUAL mode toggles the select on each sel press; AUTO
// mode toggles it every AUTO_PERIOD cycles. sel_pulse strobes for one
// cycle in the cycle where s takes its new value.

// sel_debounce: 2-flop synchronizer, stable-level debouncer and
// rising-edge press detector for one raw pushbutton.
module sel_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press
);

    // Counter only needs to reach DEBOUNCE_CYCLES-1 before it clears.
    localparam int unsigned CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          stable;
    logic          stable_d;
    logic [CW-1:0] cnt;

    // Two-flop synchronizer for the asynchronous button input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
        end
    end

    // Accept a level change only after it persists for DEBOUNCE_CYCLES cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            stable <= 1'b0;
        end else if (sync2 != stable) begin
            if (cnt == CNT_LAST) begin
                stable <= sync2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end else begin
            cnt <= '0;
        end
    end

    // One-cycle press strobe on a 0-to-1 change of the stable level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_d <= 1'b0;
            press    <= 1'b0;
        end else begin
            stable_d <= stable;
            press    <= stable & ~stable_d;
        end
    end

endmodule

module sel_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned AUTO_PERIOD     = 50000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_sel,
    input  logic btn_mode,
    output logic s,
    output logic auto_mode,
    output logic sel_pulse
);

    localparam int unsigned PW = (AUTO_PERIOD > 2) ? $clog2(AUTO_PERIOD) : 1;
    localparam logic [PW-1:0] PER_LAST = PW'(AUTO_PERIOD - 1);

    typedef enum logic {
        MANUAL = 1'b0,
        AUTO   = 1'b1
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [PW-1:0] per_cnt;
    logic [PW-1:0] per_next;
    logic          s_next;
    logic          pulse_next;
    logic          sel_press;
    logic          mode_press;

    sel_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb_sel (
        .clk  (clk),
        .rst_n(rst_n),
        .btn  (btn_sel),
        .press(sel_press)
    );

    sel_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb_mode (
        .clk  (clk),
        .rst_n(rst_n),
        .btn  (btn_mode),
        .press(mode_press)
    );

    // State, period counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= MANUAL;
            per_cnt   <= '0;
            s         <= 1'b0;
            auto_mode <= 1'b0;
            sel_pulse <= 1'b0;
        end else begin
            state     <= state_next;
            per_cnt   <= per_next;
            s         <= s_next;
            auto_mode <= (state_next == AUTO);
            sel_pulse <= pulse_next;
        end
    end

    // Next-state logic; a mode press takes priority over any select toggle.
    always_comb begin
        state_next = state;
        per_next   = per_cnt;
        s_next     = s;
        pulse_next = 1'b0;
        case (state)
            MANUAL: begin
                per_next = '0;
                if (mode_press) begin
                    state_next = AUTO;
                end else if (sel_press) begin
                    s_next     = ~s;
                    pulse_next = 1'b1;
                end
            end
            AUTO: begin
                if (mode_press) begin
                    state_next = MANUAL;
                    per_next   = '0;
                end else if (per_cnt == PER_LAST) begin
                    s_next     = ~s;
                    pulse_next = 1'b1;
                    per_next   = '0;
                end else begin
                    per_next = per_cnt + PW'(1);
                end
            end
            default: begin
                state_next = MANUAL;
                per_next   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_sel_sequencer.sv
// Directed bench for sel_sequencer with DEBOUNCE_CYCLES=4, AUTO_PERIOD=8.
// A button held from before edge k produces its FSM effect at edge k+7.
module tb_sel_sequencer;

    logic clk;
    logic rst_n;
    logic btn_sel;
    logic btn_mode;
    logic s;
    logic auto_mode;
    logic sel_pulse;

    int unsigned total;
    int unsigned passed;

    typedef struct {
        logic sel;
        logic mode;
        logic exp_s;
        logic exp_auto;
        logic exp_pulse;
    } vec_t;

    vec_t vecs[26];

    sel_sequencer #(
        .DEBOUNCE_CYCLES(4),
        .AUTO_PERIOD(8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_sel  (btn_sel),
        .btn_mode (btn_mode),
        .s        (s),
        .auto_mode(auto_mode),
        .sel_pulse(sel_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic act, input logic exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0b expected %0b (t=%0t)", name, act, exp, $time);
    endtask

    task automatic check_all(input string tag, input int k, input logic es, input logic ea, input logic ep);
        check($sformatf("%s[%0d].s", tag, k), s, es);
        check($sformatf("%s[%0d].auto_mode", tag, k), auto_mode, ea);
        check($sformatf("%s[%0d].sel_pulse", tag, k), sel_pulse, ep);
    endtask

    // Drive inputs, let one rising edge pass, return on the falling edge.
    task automatic cycle(input logic sel, input logic mode);
        btn_sel  = sel;
        btn_mode = mode;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        total    = 0;
        passed   = 0;
        rst_n    = 1'b1;
        btn_sel  = 1'b1;
        btn_mode = 1'b0;

        // Table: btn_sel held across reset release, released, pressed again.
        for (int i = 0; i < 26; i++) begin
            int k;
            k = i + 1;
            vecs[i].sel       = (k <= 10) || (k >= 17);
            vecs[i].mode      = 1'b0;
            vecs[i].exp_s     = (k >= 8) && (k < 24);
            vecs[i].exp_auto  = 1'b0;
            vecs[i].exp_pulse = (k == 8) || (k == 24);
        end

        // Asynchronous reset before any clock edge.
        #1 rst_n = 1'b0;
        #1 check_all("reset", 0, 1'b0, 1'b0, 1'b0);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 26; i++) begin
            cycle(vecs[i].sel, vecs[i].mode);
            check_all("manual", i + 1, vecs[i].exp_s, vecs[i].exp_auto, vecs[i].exp_pulse);
        end

        // Bounce: toggle every 2 cycles for 20 cycles, then settle low.
        for (int i = 0; i < 30; i++) begin
            logic b;
            b = (i < 20) ? (((i / 2) % 2) == 0) : 1'b0;
            cycle(b, 1'b0);
            check_all("bounce", i + 1, 1'b0, 1'b0, 1'b0);
        end

        // AUTO: enter at edge 8, toggles at 16/24/32; sel press ignored
        // (would act at 26); second mode press acts at edge 40 on terminal count.
        for (int k = 1; k <= 48; k++) begin
            logic m;
            logic b;
            logic es;
            m  = (k <= 8) || (k >= 33 && k <= 40);
            b  = (k >= 19) && (k <= 27);
            es = (k >= 16 && k < 24) || (k >= 32);
            cycle(b, m);
            check_all("auto", k, es, (k >= 8) && (k < 40), (k == 16) || (k == 24) || (k == 32));
        end

        // Simultaneous mode and sel presses in MANUAL: mode wins, s stays 1.
        // Run until the period counter reads 5 (entry at edge 8).
        for (int k = 1; k <= 13; k++) begin
            logic b;
            b = (k <= 8);
            cycle(b, b);
            check_all("coinc", k, 1'b1, (k >= 8), 1'b0);
        end

        // Reset mid-period, between clock edges.
        #2 rst_n = 1'b0;
        #1 check_all("midreset", 0, 1'b0, 1'b0, 1'b0);
        #1 rst_n = 1'b1;

        for (int k = 1; k <= 20; k++) begin
            cycle(1'b0, 1'b0);
            check_all("postreset", k, 1'b0, 1'b0, 1'b0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
